// File: rtl/tetris_move_arbiter.sv
// Button debouncer, gravity tick generator and command sequencer feeding the tetris piece engine.
// One command is in flight at a time over a valid/ready/done handshake; blocked downward steps raise lock.
module tetris_move_arbiter #(
    parameter int FALL_DIV = 12_500_000,
    parameter int DEBOUNCE = 250_000
) (
    input  logic       iVGA_CLK,
    input  logic       reset,
    input  logic       up,
    input  logic       left,
    input  logic       down,
    input  logic       right,
    input  logic       enable,
    output logic       cmd_valid,
    output logic [2:0] cmd,
    input  logic       cmd_ready,
    input  logic       cmd_done,
    input  logic       cmd_hit,
    output logic       lock,
    output logic       fall_down_clk,
    output logic       busy
);

    localparam int FW = $clog2(FALL_DIV);
    localparam int DW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_LOCK  = 2'd3;

    localparam logic [2:0] CMD_IDLE   = 3'd0;
    localparam logic [2:0] CMD_LEFT   = 3'd1;
    localparam logic [2:0] CMD_RIGHT  = 3'd2;
    localparam logic [2:0] CMD_ROTATE = 3'd3;
    localparam logic [2:0] CMD_DOWN   = 3'd4;
    localparam logic [2:0] CMD_GRAV   = 3'd5;

    // Button index: 0 up, 1 left, 2 right, 3 down.
    logic [3:0]    btn_raw_s;
    logic [3:0]    sync1_r;
    logic [3:0]    sync2_r;
    logic [3:0]    acc_r;
    logic [3:0]    press_r;
    logic [DW-1:0] deb_cnt_r [4];

    logic [FW-1:0] grav_cnt_r;
    logic          fall_r;

    // Pending bit order is grant priority: 0 gravity, 1 rotate, 2 left, 3 right, 4 down.
    logic [4:0]    pend_r;
    logic [4:0]    pend_set_s;
    logic [4:0]    pend_clr_s;

    logic [1:0]    state_r;
    logic [1:0]    state_nx_s;
    logic [2:0]    cmd_r;
    logic [2:0]    cmd_nx_s;
    logic          cmd_valid_r;
    logic          lock_r;
    logic          busy_r;

    assign btn_raw_s  = {down, right, left, up};
    assign pend_set_s = {press_r[3], press_r[2], press_r[1], press_r[0], fall_r};

    assign cmd_valid     = cmd_valid_r;
    assign cmd           = cmd_r;
    assign lock          = lock_r;
    assign fall_down_clk = fall_r;
    assign busy          = busy_r;

    // Synchronize the raw pins, debounce each level and pulse on an accepted press.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            sync1_r <= 4'b1111;
            sync2_r <= 4'b1111;
            acc_r   <= 4'b1111;
            press_r <= 4'b0000;
            for (int i = 0; i < 4; i++) begin
                deb_cnt_r[i] <= '0;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 4; i++) begin
                if (sync2_r[i] != acc_r[i]) begin
                    if (deb_cnt_r[i] == DW'(DEBOUNCE - 1)) begin
                        acc_r[i]     <= sync2_r[i];
                        deb_cnt_r[i] <= '0;
                        // Old level high means the new accepted level is a press.
                        press_r[i]   <= acc_r[i];
                    end else begin
                        deb_cnt_r[i] <= deb_cnt_r[i] + 1'b1;
                        press_r[i]   <= 1'b0;
                    end
                end else begin
                    deb_cnt_r[i] <= '0;
                    press_r[i]   <= 1'b0;
                end
            end
        end
    end

    // Gravity divider: free-runs while enabled, parked at zero while paused.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            grav_cnt_r <= '0;
            fall_r     <= 1'b0;
        end else if (!enable) begin
            grav_cnt_r <= '0;
            fall_r     <= 1'b0;
        end else if (grav_cnt_r == FW'(FALL_DIV - 1)) begin
            grav_cnt_r <= '0;
            fall_r     <= 1'b1;
        end else begin
            grav_cnt_r <= grav_cnt_r + 1'b1;
            fall_r     <= 1'b0;
        end
    end

    // Pending requests: set wins over clear, everything flushed while paused.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            pend_r <= 5'b00000;
        end else if (!enable) begin
            pend_r <= 5'b00000;
        end else begin
            pend_r <= (pend_r & ~pend_clr_s) | pend_set_s;
        end
    end

    // Next-state, grant selection and pending clears of the command sequencer.
    always_comb begin
        state_nx_s = state_r;
        cmd_nx_s   = cmd_r;
        pend_clr_s = 5'b00000;
        case (state_r)
            ST_IDLE: begin
                cmd_nx_s = CMD_IDLE;
                if (enable && (pend_r != 5'b00000)) begin
                    state_nx_s = ST_ISSUE;
                    if (pend_r[0]) begin
                        cmd_nx_s   = CMD_GRAV;
                        pend_clr_s = 5'b00001;
                    end else if (pend_r[1]) begin
                        cmd_nx_s   = CMD_ROTATE;
                        pend_clr_s = 5'b00010;
                    end else if (pend_r[2]) begin
                        cmd_nx_s   = CMD_LEFT;
                        pend_clr_s = 5'b00100;
                    end else if (pend_r[3]) begin
                        cmd_nx_s   = CMD_RIGHT;
                        pend_clr_s = 5'b01000;
                    end else begin
                        cmd_nx_s   = CMD_DOWN;
                        pend_clr_s = 5'b10000;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cmd_ready) begin
                    state_nx_s = ST_WAIT;
                end else begin
                    state_nx_s = ST_ISSUE;
                end
            end
            ST_WAIT: begin
                if (cmd_done) begin
                    // Only a blocked downward step fixes the piece; blocked side moves are dropped.
                    if (cmd_hit && ((cmd_r == CMD_GRAV) || (cmd_r == CMD_DOWN))) begin
                        state_nx_s = ST_LOCK;
                    end else begin
                        state_nx_s = ST_IDLE;
                        cmd_nx_s   = CMD_IDLE;
                    end
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            ST_LOCK: begin
                state_nx_s = ST_IDLE;
                cmd_nx_s   = CMD_IDLE;
                pend_clr_s = 5'b10001;
            end
            default: begin
                state_nx_s = ST_IDLE;
                cmd_nx_s   = CMD_IDLE;
            end
        endcase
    end

    // Sequencer state and registered handshake outputs.
    always_ff @(posedge iVGA_CLK or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            cmd_r       <= CMD_IDLE;
            cmd_valid_r <= 1'b0;
            lock_r      <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_nx_s;
            cmd_r       <= cmd_nx_s;
            cmd_valid_r <= (state_nx_s == ST_ISSUE);
            lock_r      <= (state_nx_s == ST_LOCK);
            busy_r      <= (state_nx_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_tetris_move_arbiter.sv
// Randomized scoreboard bench for tetris_move_arbiter: a behavioural model predicts every
// command issue, gravity tick and per-cycle output; a monitor pops and compares.
module tb_tetris_move_arbiter;

    localparam int F = 16;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset, up, left, down, right, enable;
    logic       cmd_valid, cmd_ready, cmd_done, cmd_hit, lock, fall_down_clk, busy;
    logic [2:0] cmd;

    tetris_move_arbiter #(.FALL_DIV(F), .DEBOUNCE(D)) dut (
        .iVGA_CLK(clk), .reset(reset), .up(up), .left(left), .down(down), .right(right),
        .enable(enable), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .cmd_done(cmd_done), .cmd_hit(cmd_hit), .lock(lock), .fall_down_clk(fall_down_clk),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard queues: issue events (edge*8+cmd), tick edges, per-edge output vectors.
    int q_cmd[$];
    int q_tick[$];
    int q_out[$];

    // Behavioural model state. Button index: 0 up, 1 left, 2 right, 3 down.
    bit pin[4];
    bit h1[4], h2[4], acc[4], prs[4];
    int run[4];
    int en_run;
    bit tick_v;
    bit pend[6];
    int phase;   // 0 idle, 1 offering, 2 engine busy, 3 locking
    int mcmd;
    int btn_cmd[4] = '{3, 1, 2, 4};
    int prio[5]    = '{5, 3, 1, 2, 4};

    // Stimulus controls
    bit pin_dir[4];
    int pcnt[4];
    bit rand_btn = 0, rand_en = 0, en_dir = 0;
    bit fast = 1, hit_mode = 0, no_ready = 0;
    int ecnt = 0;
    int eng_cnt = 0;

    // Monitor bookkeeping
    bit prev_valid = 0;
    int left_rises = 0;
    int last_left_cyc = -1;
    int first_tick_cyc = -1;

    task automatic chk(input string name, input int got, input int need);
        checks++;
        if (got != need) begin
            errors++;
            $display("FAIL %s: got %0d need %0d", name, got, need);
        end
    endtask

    task automatic model_init();
        for (int b = 0; b < 4; b++) begin
            h1[b] = 1; h2[b] = 1; acc[b] = 1; prs[b] = 0; run[b] = 0;
        end
        for (int c = 0; c < 6; c++) pend[c] = 0;
        en_run = 0; tick_v = 0; phase = 0; mcmd = 0;
    endtask

    // Advance the model across edge e using the inputs currently driven.
    task automatic model_step(input int e);
        bit clr[6];
        bit st[6];
        bit nprs[4];
        bit any;
        int nphase, ncmd, g;
        any = 0;
        for (int c = 0; c < 6; c++) begin clr[c] = 0; st[c] = 0; any = any | pend[c]; end
        st[5] = tick_v;
        for (int b = 0; b < 4; b++) st[btn_cmd[b]] = prs[b];
        nphase = phase; ncmd = mcmd;
        case (phase)
            0: begin
                ncmd = 0;
                if (enable && any) begin
                    g = 0;
                    for (int k = 4; k >= 0; k--) if (pend[prio[k]]) g = prio[k];
                    ncmd = g; clr[g] = 1; nphase = 1;
                    q_cmd.push_back(e * 8 + g);
                end
            end
            1: if (cmd_ready) nphase = 2;
            2: if (cmd_done) begin
                if (cmd_hit && (mcmd == 5 || mcmd == 4)) nphase = 3;
                else begin nphase = 0; ncmd = 0; end
            end
            default: begin clr[5] = 1; clr[4] = 1; nphase = 0; ncmd = 0; end
        endcase
        for (int c = 1; c < 6; c++) pend[c] = enable ? ((pend[c] && !clr[c]) || st[c]) : 1'b0;
        for (int b = 0; b < 4; b++) begin
            nprs[b] = 0;
            if (h2[b] != acc[b]) begin
                if (run[b] + 1 == D) begin nprs[b] = acc[b]; acc[b] = h2[b]; run[b] = 0; end
                else run[b] = run[b] + 1;
            end else run[b] = 0;
            h2[b] = h1[b]; h1[b] = pin[b]; prs[b] = nprs[b];
        end
        if (enable) begin en_run = en_run + 1; tick_v = (en_run % F == 0); end
        else begin en_run = 0; tick_v = 0; end
        if (tick_v) q_tick.push_back(e);
        phase = nphase; mcmd = ncmd;
        q_out.push_back(((phase == 1) ? 32 : 0) + ((phase == 3) ? 16 : 0) + ((phase != 0) ? 8 : 0) + mcmd);
    endtask

    // Drive engine responses, pins and enable for the next edge, then step the model.
    task automatic step_inputs();
        cmd_ready = 0; cmd_done = 0; cmd_hit = 0;
        if (eng_cnt > 0) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                cmd_done = 1;
                cmd_hit = hit_mode ? ($urandom % 3 == 0) : 1'b0;
            end
        end else if (cmd_valid && !no_ready) begin
            if (fast || ($urandom % 3 != 0)) begin
                cmd_ready = 1;
                eng_cnt = fast ? 1 : $urandom_range(1, 4);
            end
        end else if (!fast && !cmd_valid) begin
            cmd_ready = ($urandom % 16 == 0);
            cmd_done  = ($urandom % 16 == 0);
            cmd_hit   = ($urandom % 2 == 0);
        end
        for (int b = 0; b < 4; b++) begin
            if (!rand_btn) pin[b] = pin_dir[b];
            else if (pcnt[b] > 0) pcnt[b]--;
            else if (pin[b] == 0) begin pin[b] = 1; pcnt[b] = $urandom_range(1, 10); end
            else if ($urandom % 6 == 0) begin pin[b] = 0; pcnt[b] = $urandom_range(0, 11); end
        end
        up = pin[0]; left = pin[1]; right = pin[2]; down = pin[3];
        if (!rand_en) enable = en_dir;
        else if (ecnt > 0) ecnt--;
        else if (enable == 0) begin enable = 1; ecnt = $urandom_range(20, 300); end
        else begin enable = 0; ecnt = $urandom_range(1, 30); end
        if (!reset) model_step(cyc + 1);
    endtask

    task automatic drive_cycle();
        @(negedge clk);
        step_inputs();
    endtask

    task automatic do_reset_checks(input string tag);
        chk({tag, "_cmd_valid"}, int'(cmd_valid), 0);
        chk({tag, "_cmd"}, int'(cmd), 0);
        chk({tag, "_lock"}, int'(lock), 0);
        chk({tag, "_fall"}, int'(fall_down_clk), 0);
        chk({tag, "_busy"}, int'(busy), 0);
    endtask

    // Monitor: compares DUT outputs against the scoreboard just after each active edge.
    initial forever begin
        bit rise, exp_rise, exp_t;
        int got, need;
        @(posedge clk);
        #1;
        if (reset) begin
            prev_valid = 0;
        end else begin
            rise = cmd_valid && !prev_valid;
            exp_rise = (q_cmd.size() > 0) && (q_cmd[0] / 8 == cyc);
            if (rise || exp_rise) begin
                checks++;
                need = exp_rise ? q_cmd[0] % 8 : 0;
                if (!(rise && exp_rise && int'(cmd) == need)) begin
                    errors++;
                    $display("FAIL cmd_issue cyc=%0d: got rise=%0d cmd=%0d need rise=%0d cmd=%0d",
                             cyc, rise, cmd, exp_rise, need);
                end
                if (exp_rise) void'(q_cmd.pop_front());
            end
            if (rise && cmd == 3'd1) begin left_rises++; last_left_cyc = cyc; end
            exp_t = (q_tick.size() > 0) && (q_tick[0] == cyc);
            if (fall_down_clk || exp_t) begin
                checks++;
                if (!(fall_down_clk && exp_t)) begin
                    errors++;
                    $display("FAIL gravity_tick cyc=%0d: got %0d need %0d", cyc, fall_down_clk, exp_t);
                end
                if (exp_t) void'(q_tick.pop_front());
            end
            if (fall_down_clk && first_tick_cyc < 0) first_tick_cyc = cyc;
            if (q_out.size() > 0) begin
                got = {26'd0, cmd_valid, lock, busy, cmd};
                need = q_out.pop_front();
                checks++;
                if (got != need) begin
                    errors++;
                    $display("FAIL outputs cyc=%0d: got valid/lock/busy/cmd=%0d/%0d/%0d/%0d need %0d/%0d/%0d/%0d",
                             cyc, got[5], got[4], got[3], got % 8, need / 32, (need / 16) % 2, (need / 8) % 2, need % 8);
                end
            end
            prev_valid = cmd_valid;
        end
    end

    initial begin
        int rel_edge, press_edge, waited;
        reset = 1; enable = 0; up = 1; left = 1; down = 1; right = 1;
        cmd_ready = 0; cmd_done = 0; cmd_hit = 0;
        for (int b = 0; b < 4; b++) begin pin[b] = 1; pin_dir[b] = 1; pcnt[b] = 0; end
        model_init();
        repeat (3) @(negedge clk);
        #1 do_reset_checks("reset");

        // Release with enable high and left pressed for only three samples.
        en_dir = 1; fast = 1;
        @(negedge clk);
        reset = 0;
        rel_edge = cyc + 1;
        pin_dir[1] = 0;
        step_inputs();
        repeat (2) drive_cycle();
        pin_dir[1] = 1;
        while (cyc + 2 < rel_edge + 20) drive_cycle();
        chk("glitch_no_left", left_rises, 0);
        chk("first_tick_after_enable", first_tick_cyc, rel_edge + 15);

        // Held press: one LEFT, offered 8 edges after the pin edge.
        pin_dir[1] = 0;
        press_edge = cyc + 2;
        repeat (10) drive_cycle();
        chk("left_latency", last_left_cyc, press_edge + 7);
        pin_dir[1] = 1;
        repeat (12) drive_cycle();
        chk("left_single_cmd", left_rises, 1);

        // Randomized traffic: buttons, pauses, engine stalls, hits and stray handshakes.
        fast = 0; hit_mode = 1; rand_btn = 1; rand_en = 1;
        repeat (3000) drive_cycle();

        // Asynchronous reset while a command is on offer.
        rand_btn = 0; rand_en = 0; en_dir = 1; fast = 1; hit_mode = 0; no_ready = 1;
        for (int b = 0; b < 4; b++) pin_dir[b] = 1;
        waited = 0;
        while (!cmd_valid && waited < 100) begin drive_cycle(); waited++; end
        chk("issue_reached", int'(cmd_valid), 1);
        reset = 1;
        q_cmd.delete(); q_tick.delete(); q_out.delete();
        model_init();
        eng_cnt = 0; first_tick_cyc = -1; no_ready = 0;
        #1 do_reset_checks("midreset");
        repeat (3) drive_cycle();
        @(negedge clk);
        reset = 0;
        rel_edge = cyc + 1;
        step_inputs();
        repeat (30) drive_cycle();
        chk("tick_after_reset", first_tick_cyc, rel_edge + 15);

        // Pause and drain: nothing predicted may remain unobserved.
        en_dir = 0;
        repeat (20) drive_cycle();
        chk("cmd_queue_drained", q_cmd.size(), 0);
        chk("tick_queue_drained", q_tick.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
